// File: rtl/bram_playback_sequencer.sv
// Orbit-aligned arm/start/realign/stop sequencer for N_LINKS BRAM pattern players.
// Optional build macro BRAM_SEQ_AUTO_REARM_EN: DONE re-arms with the latched settings instead of idling.
module bram_playback_sequencer #(
    parameter int N_LINKS   = 12,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 fc_orbitSync,
    input  logic                 cfg_arm,
    input  logic                 cfg_abort,
    input  logic [CNT_WIDTH-1:0] cfg_start_delay,
    input  logic [CNT_WIDTH-1:0] cfg_n_orbits,
    input  logic [N_LINKS-1:0]   cfg_link_mask,
    output logic [N_LINKS-1:0]   link_sync,
    output logic [N_LINKS-1:0]   link_enable,
    output logic [1:0]           seq_state,
    output logic                 seq_busy,
    output logic [CNT_WIDTH-1:0] orbit_count,
    output logic                 err_empty_mask
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] dly_q, dly_d;
    logic [CNT_WIDTH-1:0] norb_q, norb_d;
    logic [N_LINKS-1:0]   mask_q, mask_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [N_LINKS-1:0]   sync_q, sync_d;
    logic [N_LINKS-1:0]   en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt_inc;
`ifdef BRAM_SEQ_AUTO_REARM_EN
    logic [CNT_WIDTH-1:0] delay_q, delay_d;
`endif

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign cnt_inc = sat_inc(cnt_q);

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        norb_d  = norb_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        sync_d  = '0;
        en_d    = en_q;
        err_d   = err_q;
`ifdef BRAM_SEQ_AUTO_REARM_EN
        delay_d = delay_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cfg_arm) begin
                    if (|cfg_link_mask) begin
                        state_d = S_ARMED;
                        dly_d   = cfg_start_delay;
                        norb_d  = cfg_n_orbits;
                        mask_d  = cfg_link_mask;
                        cnt_d   = '0;
                        err_d   = 1'b0;
`ifdef BRAM_SEQ_AUTO_REARM_EN
                        delay_d = cfg_start_delay;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (cfg_abort) begin
                    state_d = S_IDLE;
                    en_d    = '0;
                end else if (fc_orbitSync) begin
                    if (dly_q != '0) begin
                        dly_d = dly_q - CNT_WIDTH'(1);
                    end else begin
                        state_d = S_RUN;
                        sync_d  = mask_q;
                        en_d    = mask_q;
                        cnt_d   = '0;
                    end
                end
            end
            S_RUN: begin
                if (cfg_abort) begin
                    state_d = S_IDLE;
                    en_d    = '0;
                end else if (fc_orbitSync) begin
                    cnt_d = cnt_inc;
                    // The stop point uses the orbit count latched at arm time, never the live input.
                    if ((norb_q != '0) && (cnt_inc == norb_q)) begin
                        state_d = S_DONE;
                        en_d    = '0;
                    end else begin
                        sync_d = mask_q;
                    end
                end
            end
            default: begin
`ifdef BRAM_SEQ_AUTO_REARM_EN
                state_d = S_ARMED;
                dly_d   = delay_q;
`else
                state_d = S_IDLE;
`endif
            end
        endcase
        busy_d = (state_d == S_ARMED) || (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            norb_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            sync_q  <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef BRAM_SEQ_AUTO_REARM_EN
            delay_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            norb_q  <= norb_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef BRAM_SEQ_AUTO_REARM_EN
            delay_q <= delay_d;
`endif
        end
    end

    assign link_sync      = sync_q;
    assign link_enable    = en_q;
    assign seq_state      = state_q;
    assign seq_busy       = busy_q;
    assign orbit_count    = cnt_q;
    assign err_empty_mask = err_q;

endmodule
